// File: rtl/fp_mult_pkg.sv
// Shared definitions for the floating-point multiplier dispatcher: widths, flow codes,
// FSM state encoding and the flow-code sanitiser.
package fp_mult_pkg;

    localparam int OP_W    = 32;
    localparam int FLOW_W  = 2;
    localparam int ENTRY_W = 2 * OP_W;

    localparam logic [FLOW_W-1:0] FLOW_NORMAL  = 2'b00;
    localparam logic [FLOW_W-1:0] FLOW_OVER    = 2'b01;
    localparam logic [FLOW_W-1:0] FLOW_UNDER   = 2'b10;
    localparam logic [FLOW_W-1:0] FLOW_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Only the local watchdog may report a timeout; a multiplier driving 11 is read as normal.
    function automatic logic [FLOW_W-1:0] sanitize_flow(input logic [FLOW_W-1:0] flow);
        case (flow)
            FLOW_OVER:    sanitize_flow = FLOW_OVER;
            FLOW_UNDER:   sanitize_flow = FLOW_UNDER;
            FLOW_TIMEOUT: sanitize_flow = FLOW_NORMAL;
            default:      sanitize_flow = FLOW_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// Operand-pair FIFO for the multiplier dispatcher: 64-bit entries {a, b}, power-of-two depth,
// synchronous active-high reset, combinational read of the head entry.
module fp_op_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRY_W-1:0]       din,
    output logic [ENTRY_W-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO may still take a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mult_dispatch.sv
// Queues operand pairs and feeds them one at a time to an external FP multiplier, returning
// each product with its flow code. Define FP_DISPATCH_TIMEOUT_EN to add the WAIT watchdog.
module fp_mult_dispatch
    import fp_mult_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_rst,
    input  logic [31:0] mult_c,
    input  logic        mult_done,
    input  logic [1:0]  mult_flow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic [1:0]  out_flow,
    output logic        busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state;
    state_t             state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               push;
    logic               pop;
    logic               capture;
    logic               timed_out;
    logic               timeout_hit;

    assign in_ready = !reset && !fifo_full;
    assign push     = in_valid && in_ready;

    fp_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FP_DISPATCH_TIMEOUT_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] watchdog;

    // Counts completed WAIT cycles; the limit is reached on the last permitted WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset || state == ST_LAUNCH) begin
            watchdog <= '0;
        end else if (state == ST_WAIT) begin
            watchdog <= watchdog + 10'd1;
        end
    end

    assign timeout_hit = (watchdog == WD_LAST);
`else
    // No watchdog in this build; the term is constant false for every legal limit.
    assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done) begin
                    capture    = 1'b1;
                    state_next = ST_OUTPUT;
                end else if (timeout_hit) begin
                    timed_out  = 1'b1;
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operands stay put from the pop until the next pop; results stay put until the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult_a   <= '0;
            mult_b   <= '0;
            out_c    <= '0;
            out_flow <= FLOW_NORMAL;
        end else begin
            if (pop) begin
                mult_a <= fifo_head[ENTRY_W-1:OP_W];
                mult_b <= fifo_head[OP_W-1:0];
            end
            if (capture) begin
                out_c    <= mult_c;
                out_flow <= sanitize_flow(mult_flow);
            end else if (timed_out) begin
                out_c    <= '0;
                out_flow <= FLOW_TIMEOUT;
            end
        end
    end

    assign mult_rst  = reset || (state == ST_LAUNCH);
    assign out_valid = !reset && (state == ST_OUTPUT);
    assign busy      = !reset && ((state != ST_IDLE) || (fifo_count != '0));

endmodule

// File: tb/tb_fp_mult_dispatch.sv
// Self-checking bench for fp_mult_dispatch: behavioural FP multiplier, result scoreboard and
// directed scenarios (basic product, flow codes, backpressure, watchdog, reset mid-operation).
module tb_fp_mult_dispatch;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_rst;
    logic [31:0] mult_c = '0;
    logic        mult_done = 1'b0;
    logic [1:0]  mult_flow = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [1:0]  out_flow;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    time         launch_t = 0;
    time         push_t = 0;
    time         valid_t = 0;
    bit          prev_launch = 1'b0;
    int          mult_lat = 3;
    bit          mult_hang = 1'b0;
    int          mcnt = 0;
    bit          fifth_accepted = 1'b0;

    always #5 clk = ~clk;

    fp_mult_dispatch #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_rst  (mult_rst),
        .mult_c    (mult_c),
        .mult_done (mult_done),
        .mult_flow (mult_flow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_flow  (out_flow),
        .busy      (busy)
    );

    // Single-precision multiply for normal operands, truncating; returns {flow, product}.
    function automatic logic [33:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [22:0] man;
        int          e;
        logic        sign;
        sign = a[31] ^ b[31];
        prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            man = prod[46:24];
            e   = e + 1;
        end else begin
            man = prod[45:23];
        end
        if (e >= 255) return {2'b01, 32'h0};
        if (e <= 0)   return {2'b10, 32'h0};
        return {2'b00, sign, e[7:0], man};
    endfunction

    // Multiplier: restarts on mult_rst, raises a sticky done mult_lat cycles later.
    always @(posedge clk) begin
        if (mult_rst) begin
            mult_done <= 1'b0;
            mcnt      <= 0;
        end else if (!mult_done && !mult_hang) begin
            if (mcnt + 1 >= mult_lat) begin
                mult_done              <= 1'b1;
                {mult_flow, mult_c}    <= fpmul(mult_a, mult_b);
            end
            mcnt <= mcnt + 1;
        end
    end

    task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Scoreboard: every accepted pair must come back, in order, with the modelled product.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_launch = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_output: got out_c=%h out_flow=%b, expected no result", out_c, out_flow);
                end else begin
                    checkValue("model_result", {30'h0, out_flow, out_c}, {30'h0, exp_q[0]});
                    if (out_ready) exp_q.pop_front();
                end
            end
            if (mult_rst) begin
                checkValue("mult_rst_single_cycle", 64'(prev_launch), 64'd0);
                launch_t = $time;
            end
            prev_launch = mult_rst;
            if (in_valid && in_ready) begin
                if (mult_hang) begin
`ifdef FP_DISPATCH_TIMEOUT_EN
                    exp_q.push_back({2'b11, 32'h0});
`endif
                end else begin
                    exp_q.push_back(fpmul(in_a, in_b));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                push_t   = $time;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkValue("push_accepted", 64'(accepted), 64'd1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] c, input logic [1:0] flow);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen    = 1'b1;
                valid_t = $time;
                checkValue({name, "_c"}, 64'(out_c), 64'(c));
                checkValue({name, "_flow"}, 64'(out_flow), 64'(flow));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_no_output: got no out_valid, expected a result", name);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int vcount;

        checkValue("pin_one_times_two", 64'(fpmul(32'h3F800000, 32'h40000000)), 64'h0_4000_0000);
        checkValue("pin_three_times_neg_two", 64'(fpmul(32'h40400000, 32'hC0000000)), 64'h0_C0C0_0000);
        checkValue("pin_onehalf_squared", 64'(fpmul(32'h3FC00000, 32'h3FC00000)), 64'h0_4010_0000);
        checkValue("pin_underflow", 64'(fpmul(32'h00800000, 32'h00800000)), 64'h2_0000_0000);
        checkValue("pin_overflow", 64'(fpmul(32'h7F000000, 32'h7F000000)), 64'h1_0000_0000);

        $display("[TB] reset");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkValue("reset_in_ready", 64'(in_ready), 64'd0);
        checkValue("reset_out_valid", 64'(out_valid), 64'd0);
        checkValue("reset_busy", 64'(busy), 64'd0);
        checkValue("reset_mult_rst", 64'(mult_rst), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkValue("post_reset_out_c", 64'(out_c), 64'd0);
        checkValue("post_reset_out_flow", 64'(out_flow), 64'd0);
        checkValue("post_reset_mult_a", 64'(mult_a), 64'd0);
        checkValue("post_reset_mult_b", 64'(mult_b), 64'd0);
        checkValue("post_reset_in_ready", 64'(in_ready), 64'd1);
        checkValue("post_reset_busy", 64'(busy), 64'd0);
        checkValue("post_reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] single product and latency");
        out_ready = 1'b1;
        mult_lat  = 3;
        applyStimulus(32'h3F800000, 32'h40000000);
        checkOutput("one_times_two", 32'h40000000, 2'b00);
        checkValue("push_to_launch_time", 64'(launch_t - push_t), 64'd20);
        checkValue("launch_to_valid_time", 64'(valid_t - launch_t), 64'd50);

        $display("[TB] underflow then overflow");
        applyStimulus(32'h00800000, 32'h00800000);
        applyStimulus(32'h7F000000, 32'h7F000000);
        checkOutput("underflow", 32'h00000000, 2'b10);
        checkOutput("overflow", 32'h00000000, 2'b01);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(32'h40400000, 32'hC0000000);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        @(posedge clk);
        #1;
        applyStimulus(32'h3F800000, 32'h40000000);
        applyStimulus(32'h3FC00000, 32'h3FC00000);
        applyStimulus(32'h40400000, 32'h40400000);
        applyStimulus(32'h00800000, 32'h00800000);
        in_valid = 1'b1;
        in_a     = 32'h7F000000;
        in_b     = 32'h7F000000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkValue("in_ready_when_full", 64'(in_ready), 64'd0);
            checkValue("stalled_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin
                fifth_accepted = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (in_ready) begin
                        fifth_accepted = 1'b1;
                        break;
                    end
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                checkValue("fifth_push_accepted", 64'(fifth_accepted), 64'd1);
            end
            begin
                checkOutput("bp_r0", 32'hC0C00000, 2'b00);
                checkOutput("bp_r1", 32'h40000000, 2'b00);
                checkOutput("bp_r2", 32'h40100000, 2'b00);
                checkOutput("bp_r3", 32'h41100000, 2'b00);
                checkOutput("bp_r4", 32'h00000000, 2'b10);
                checkOutput("bp_r5", 32'h00000000, 2'b01);
            end
        join

        $display("[TB] multiplier never completes");
        mult_hang = 1'b1;
        applyStimulus(32'h3F800000, 32'h40000000);
`ifdef FP_DISPATCH_TIMEOUT_EN
        checkOutput("timeout", 32'h00000000, 2'b11);
        checkValue("timeout_wait_time", 64'(valid_t - launch_t), 64'((TMO + 1) * 10));
`else
        vcount = 0;
        repeat (1000) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        checkValue("no_watchdog_out_valid_cycles", 64'(vcount), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mult_hang = 1'b0;

        $display("[TB] reset during WAIT");
        mult_lat = 40;
        applyStimulus(32'h3F800000, 32'h40000000);
        applyStimulus(32'h3FC00000, 32'h3FC00000);
        applyStimulus(32'h40400000, 32'h40400000);
        applyStimulus(32'h40400000, 32'hC0000000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("busy_mid_wait", 64'(busy), 64'd1);
        checkValue("mid_wait_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkValue("in_ready_during_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkValue("after_reset_out_valid", 64'(out_valid), 64'd0);
        checkValue("after_reset_busy", 64'(busy), 64'd0);
        checkValue("after_reset_in_ready", 64'(in_ready), 64'd1);
        vcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        checkValue("no_stale_result_cycles", 64'(vcount), 64'd0);
        @(posedge clk);
        #1;
        mult_lat = 2;
        applyStimulus(32'h40400000, 32'h40400000);
        checkOutput("after_reset_product", 32'h41100000, 2'b00);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got no completion, expected $finish before time limit");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
